// File: rtl/leaky_int7p8_if.sv
// Sample/result bus for the 7/8 leaky integrator: input handshake plus registered result.
interface leaky_int7p8_if #(
  parameter int unsigned W  = 5,
  parameter int unsigned WA = 6
);
  logic signed [W-1:0]  x_in;
  logic                 x_valid;
  logic                 ready;
  logic signed [WA-1:0] y_out;
  logic                 y_valid;
  logic                 ovf;

  modport master (
    output x_in, x_valid,
    input  ready, y_out, y_valid, ovf
  );

  modport slave (
    input  x_in, x_valid,
    output ready, y_out, y_valid, ovf
  );
endinterface

// File: rtl/leaky_int7p8.sv
// First-order leaky integrator y = y - y/8 + x with saturation and sticky overflow.
// Define LEAKY_ROUND_EN to round the decay term half-up instead of flooring it.
module leaky_int7p8 #(
  parameter int unsigned W  = 5,
  parameter int unsigned WA = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  leaky_int7p8_if.slave  bus
);

  localparam int unsigned WS = WA + 2;
  localparam int unsigned WD = WA + 1;
  localparam logic signed [WS-1:0] SAT_MAX = WS'((1 << (WA - 1)) - 1);
  localparam logic signed [WS-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCALE = 2'd1,
    ACCUM = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic signed [WA-1:0] acc_q, acc_d;
  logic signed [WS-1:0] x_q, x_d;
  logic signed [WD-1:0] dec_q, dec_d;
  logic signed [WA-1:0] y_q, y_d;
  logic                 y_valid_q, y_valid_d;
  logic                 ovf_q, ovf_d;
  logic                 ready_q, ready_d;

  logic signed [W-1:0]  x_c;
  logic signed [WD-1:0] dec_c;
  logic signed [WS-1:0] sum_c;

  assign x_c = bus.x_in;

`ifdef LEAKY_ROUND_EN
  // Half-up rounding; WA+1 bits keeps acc+4 from wrapping at the positive rail.
  logic signed [WD-1:0] rnd_c;
  assign rnd_c = WD'(acc_q) + WD'(4);
  assign dec_c = rnd_c >>> 3;
`else
  assign dec_c = WD'(acc_q >>> 3);
`endif

  assign sum_c = WS'(acc_q) - WS'(dec_q) + x_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      x_q       <= '0;
      dec_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      x_q       <= x_d;
      dec_q     <= dec_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      ovf_q     <= ovf_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    x_d       = x_q;
    dec_d     = dec_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    ovf_d     = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.x_valid && ready_q) begin
          x_d     = WS'(x_c);
          state_d = SCALE;
        end
      end
      SCALE: begin
        dec_d   = dec_c;
        state_d = ACCUM;
      end
      ACCUM: begin
        if (sum_c > SAT_MAX) begin
          acc_d = WA'(SAT_MAX);
          ovf_d = 1'b1;
        end else if (sum_c < SAT_MIN) begin
          acc_d = WA'(SAT_MIN);
          ovf_d = 1'b1;
        end else begin
          acc_d = WA'(sum_c);
        end
        y_d       = acc_d;
        y_valid_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear drops any in-flight sample and blocks acceptance this cycle.
    if (clear) begin
      state_d   = IDLE;
      acc_d     = '0;
      y_d       = '0;
      ovf_d     = 1'b0;
      y_valid_d = 1'b0;
    end

    ready_d = (state_d == IDLE);
  end

  assign bus.ready   = ready_q;
  assign bus.y_out   = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_leaky_int7p8.sv
// Scoreboard bench for leaky_int7p8: directed samples push expected results, a monitor pops on y_valid.
module tb_leaky_int7p8;

  localparam int unsigned W  = 5;
  localparam int unsigned WA = 6;

  logic clk = 1'b0;
  logic reset;
  logic clear;

  always #5 clk = ~clk;

  leaky_int7p8_if #(.W(W), .WA(WA)) bus ();

  leaky_int7p8 #(.W(W), .WA(WA)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct {
    int y;
    bit ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   bp_x[12] = '{2, 9, 9, 3, 9, 9, -1, 9, 9, 4, 9, 9};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every y_valid pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.y_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("y_valid_unexpected", int'(bus.y_valid), 0);
        end else begin
          mon_e = sb.pop_front();
          chk("y_out", int'(bus.y_out), mon_e.y);
          chk("ovf", int'(bus.ovf), int'(mon_e.ovf));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Wait (bounded) for ready, then present x for exactly one edge; returns at the negedge after acceptance.
  task automatic accept(input int x);
    int n = 0;
    while (bus.ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", int'(bus.ready), 1);
    bus.x_in    = W'(x);
    bus.x_valid = 1'b1;
    @(negedge clk);
    bus.x_valid = 1'b0;
  endtask

  task automatic send(input int x, input int y, input bit ovf);
    exp_t e;
    e.y   = y;
    e.ovf = ovf;
    sb.push_back(e);
    accept(x);
    chk("ready_busy1", int'(bus.ready), 0);
    @(negedge clk);
    chk("ready_busy2", int'(bus.ready), 0);
    chk("y_valid_early", int'(bus.y_valid), 0);
    @(negedge clk);
    chk("ready_back", int'(bus.ready), 1);
    chk("y_valid_pulse", int'(bus.y_valid), 1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, int'(bus.ready), 1);
    chk({tag, "_y_out"}, int'(bus.y_out), 0);
    chk({tag, "_y_valid"}, int'(bus.y_valid), 0);
    chk({tag, "_ovf"}, int'(bus.ovf), 0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_idle("clear");
  endtask

  initial begin
    reset       = 1'b1;
    clear       = 1'b0;
    bus.x_in    = W'(5);
    bus.x_valid = 1'b1;
    repeat (2) @(negedge clk);
    reset       = 1'b0;
    bus.x_valid = 1'b0;
    check_idle("reset");
    @(negedge clk);
    chk("reset_sample_dropped", int'(bus.ready), 1);

    // Step response: floor decay settles at 8 for x=1.
    for (int i = 0; i < 10; i++) send(1, (i < 7) ? i + 1 : 8, 1'b0);

    pulse_clear();
    send(15, 15, 1'b0);
    send(15, 29, 1'b0);
    send(15, 31, 1'b1);
    send(15, 31, 1'b1);

    pulse_clear();
    send(-16, -16, 1'b0);
    send(-16, -30, 1'b0);
    send(-16, -32, 1'b1);

    // Clear while the sample sits in SCALE.
    accept(5);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_idle("clear_scale");
    repeat (3) @(negedge clk);
    chk("clear_scale_hold", int'(bus.y_out), 0);

    // Reset while the sample sits in ACCUM, with ovf set beforehand.
    send(15, 15, 1'b0);
    send(15, 29, 1'b0);
    send(15, 31, 1'b1);
    accept(7);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("reset_accum");
    repeat (3) @(negedge clk);
    chk("reset_accum_hold", int'(bus.y_out), 0);

    // Backpressure: x_valid held high, only every third value is taken.
    sb.push_back('{y: 2, ovf: 1'b0});
    sb.push_back('{y: 5, ovf: 1'b0});
    sb.push_back('{y: 4, ovf: 1'b0});
    sb.push_back('{y: 8, ovf: 1'b0});
    for (int i = 0; i < 12; i++) begin
      bus.x_valid = 1'b1;
      bus.x_in    = W'(bp_x[i]);
      chk("bp_ready", int'(bus.ready), (i % 3 == 0) ? 1 : 0);
      @(negedge clk);
    end
    bus.x_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Positive dead-zone with x=0.
    pulse_clear();
    send(7, 7, 1'b0);
`ifdef LEAKY_ROUND_EN
    send(0, 6, 1'b0);
    send(0, 5, 1'b0);
    send(0, 4, 1'b0);
    send(0, 3, 1'b0);
    send(0, 3, 1'b0);
`else
    send(0, 7, 1'b0);
    send(0, 7, 1'b0);
    send(0, 7, 1'b0);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/leaky_int7p8.md
Name: leaky_int7p8

Overview:
- Sequential first-order leaky integrator, y[n] = y[n-1] - y[n-1]/8 + x[n]. The feedback gain is 7/8, realised as shift-subtract (acc - acc>>>3).
- Sits directly downstream of the 5-bit signed 7/8 constant-multiplier stage and consumes its output samples.
- Uses a 3-state FSM with a valid/ready handshake and an output with saturation and an overflow flag.

Parameters:
- W, 5, input sample width (signed two's complement).
- WA, 6, accumulator/output width (signed); WA >= W.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous accumulator clear; priority below reset.
- x_in  input  W  signed input sample.
- x_valid  input  1  x_in is valid this cycle.
- ready  output  1  block can accept a sample this cycle.
- y_out  output  WA  signed accumulator value (registered).
- y_valid  output  1  one-cycle pulse: y_out updated.
- ovf  output  1  sticky saturation flag.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, acc=0, y_out=0, y_valid=0, ovf=0, ready=1.
- States:
  - IDLE (ready=1).
  - SCALE (ready=0).
  - ACCUM (ready=0).
- IDLE: if x_valid && ready at an edge, latch x_in (sign-extend to WA+2) and go to SCALE. Otherwise stay in IDLE. x_valid is ignored whenever ready=0; there is no queueing.
- SCALE: d = acc >>> 3 (arithmetic shift, floor toward -inf), registered. Go to ACCUM.
- ACCUM: s = acc - d + x, computed in WA+2 bits.
  - Saturate s to [-2^(WA-1), 2^(WA-1)-1].
  - If clamped, set ovf.
  - acc <= sat(s); y_out <= sat(s); y_valid <= 1 for exactly one cycle.
  - Go to IDLE.
- Timing: sample accepted at edge k gives y_out/y_valid valid from edge k+2, and ready=1 again from edge k+2. Throughput is one sample per 3 cycles.
- y_out holds its value between updates.
- y_valid is 0 except for the single post-ACCUM cycle.
- clear (when reset=0):
  - acc <= 0, y_out <= 0, ovf <= 0, y_valid <= 0, state <= IDLE.
  - Any in-flight sample is discarded; a sample presented in the same cycle is not accepted.
- reset in any state: returns to reset values at the next edge; an in-flight sample is discarded and no y_valid pulse is produced.
- ovf stays set until reset or clear; it does not affect arithmetic.
- Floor-shift decay:
  - With x=0, positive acc < 8 is a fixed point.
  - Negative acc decays to 0 (e.g. -1: d=-1 gives 0).
- With constant input x, steady state satisfies floor(acc/8) = x.

Optional Feature:
- Macro: LEAKY_ROUND_EN.
- Defined: d = (acc + 4) >>> 3, computed in WA+1 bits with no overflow (round half up). This reduces the positive dead-zone: with x=0, acc=7 decays 7 → 6 → 5 → 4 → 3 and then holds 3.
- Undefined: plain floor shift d = acc >>> 3 (acc=7 with x=0 holds 7).
- Latency, handshake and saturation are identical in both builds.

Test Plan:
- Reset check: assert reset 2 cycles, then release. Required: ready=1, y_out=0, y_valid=0, ovf=0. A sample presented during reset is not accepted.
- Step response (WA=6, no macro): x_in=1 offered every time ready=1, 10 samples. Required:
  - y_out sequence 1,2,3,4,5,6,7,8,8,8, each with a single y_valid pulse.
  - Each pulse comes 2 edges after acceptance; ready is low for 2 cycles per sample.
- Saturation: x_in=15 repeated. Required:
  - y_out sequence 15, 29, 31, 31.
  - ovf rises with the third output and stays 1.
  - Negative case from cleared acc: x_in=-16 gives -16, -30, -32, with ovf set at the third output.
- Backpressure: hold x_valid=1 continuously with x_in changing every cycle. Required: only the values present on cycles where ready=1 are accepted (every 3rd cycle), and exactly one y_valid per accepted sample.
- Clear/reset mid-operation: accept a sample, then assert clear in SCALE. Required: no y_valid pulse, y_out=0, ovf=0, ready=1 next cycle. Repeat with reset asserted in ACCUM; required result is the same.
- LEAKY_ROUND_EN build: load acc=7 via x_in=7, then x_in=0 repeated. Required: y_out sequence 6,5,4,3,3. Without the macro the same stimulus gives 7,7,7.
